ptr_chain: RTL and testbench
============================

# ptr_chain

Linked-list queue directly downstream of `req_gen`: every valid pointer on `in_ptr`/`in_ptr_vld` is appended to the tail of a singly linked list held in a next-pointer array. The list is drained from the head through a valid/ready output port. Pointers leave in arrival order. This is the hardware counterpart of the list operations exercised in the linked-list demo steps.

## Interface
- `PTR_W`, default 4: pointer width; the list holds up to `2**PTR_W` nodes. Defined in the package.
- `clk` input, 1: single clock; all state changes on its rising edge.
- `rst` input, 1: reset, asynchronous, active-low. Assertion clears all state immediately; release is synchronous to `clk`.
- `in_ptr` input, `Pointer`: pointer to append. Driven by `req_gen.out_ptr`.
- `in_ptr_vld` input, 1: append request. There is no ready; the block always accepts.
- `out_ptr` output, `Pointer`: current head of the list.
- `out_ptr_vld` output, 1: list non-empty; `out_ptr` is meaningful.
- `out_ptr_rdy` input, 1: consumer pops the head when `out_ptr_vld && out_ptr_rdy`.
- `count` output, `PTR_W+1`: number of nodes in the list.
- `empty` output, 1: equals `count == 0`.
- `dup_err` output, 1: one-cycle pulse when a duplicate push is rejected. Present only with the dup-check feature.

## Operation
- State: `head`, `tail`, `count`, and `next[0 .. 2**PTR_W-1]` of type `Pointer`.
- Push (`in_ptr_vld`), on an empty list: `head <= in_ptr`, `tail <= in_ptr`.
- Push on a non-empty list: `next[tail] <= in_ptr`, `tail <= in_ptr`.
- Pop (`out_ptr_vld && out_ptr_rdy`): `head <= next[head]`. `next[head]` is a combinational read of the array.
- `count` increments on push only, decrements on pop only, and is unchanged on push plus pop.
- Push plus pop with `count == 1`: `head <= in_ptr`, `tail <= in_ptr`, `count` stays 1. The `next` entry of the popped node is not used.
- Push plus pop with `count > 1`: tail append and head advance both take effect in the same cycle.
- Pop while empty: impossible, because `out_ptr_vld` is 0; `out_ptr_rdy` is ignored.
- Full condition: `count == 2**PTR_W` cannot be exceeded when pointers are unique. A push at full is a duplicate by definition.
- `out_ptr = head` and `out_ptr_vld = (count != 0)`, both driven from registers with no combinational path from the inputs.
- `next[]` is not reset; an entry is only read after it has been written.

## Timing
- Reset values: `head = 0`, `tail = 0`, `count = 0`, `empty = 1`, `out_ptr_vld = 0`, `out_ptr = 0`, `dup_err = 0`.
- Push-to-output latency: a pointer pushed at edge N into an empty list appears with `out_ptr_vld = 1` after edge N, i.e. in cycle N+1.
- Pop-to-new-head latency: the new head is visible the cycle after the pop edge.
- Sustained throughput is 1 push and 1 pop per cycle.
- Reset asserted mid-operation empties the list immediately. A push in flight in that cycle is lost.

## Configuration
- `PTR_CHAIN_DUP_CHECK_EN` defined:
  - Maintain an `in_list` bitmap of `2**PTR_W` bits.
  - A push is a duplicate when `in_list[in_ptr]` is set, unless the same cycle pops a head equal to `in_ptr`.
  - A duplicate push is dropped: no state change, and `dup_err` pulses high for one cycle.
  - Push sets the bitmap bit for the pushed pointer; pop clears the bit for the popped head. When push and pop name the same pointer, the set wins.
  - The bitmap is cleared on reset.
- `PTR_CHAIN_DUP_CHECK_EN` undefined:
  - No bitmap is built and `dup_err` is tied to 0.
  - Behaviour on a duplicate push is undefined and corrupts the list. The upstream block guarantees uniqueness.

## Structure
- Package `ptr_pkg`: `PTR_W`, `typedef logic [PTR_W-1:0] Pointer`, and `N_PTR = 2**PTR_W`. It is shared with `req_gen` and the testbench.
- Sub-module `ptr_next_ram`:
  - `N_PTR` entries of `Pointer`.
  - One synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`).
  - Isolated so it can later be swapped for an inferred RAM.
- Top level: head/tail/count control plus the optional bitmap; about 150–250 lines in total.

## Test plan
- Reset then idle: hold `rst = 0` for 2 cycles and release. Required: `count = 0`, `empty = 1`, `out_ptr_vld = 0` for 10 cycles.
- In-order drain: push 3, 7, 1 on consecutive cycles with `out_ptr_rdy = 0`, then raise `out_ptr_rdy`. Required: `out_ptr` shows 3, 7, 1 on successive cycles, then `out_ptr_vld = 0` and `count = 0`.
- Single-node push plus pop: list = {5}, then push 9 and pop in the same cycle. Required: next cycle `out_ptr = 9`, `count = 1`.
- Fill to full: with `PTR_W = 4`, push 0..15 and then pop all. Required: `count = 16` at the peak; pops return 0..15 in order.
- Duplicate rejection (with `PTR_CHAIN_DUP_CHECK_EN`):
  - List = {2, 4}; push 4. Required: `dup_err = 1` for one cycle and `count` stays 2.
  - Then pop 2 while pushing 2. Required: accepted, list becomes {4, 2}.
- Async reset mid-stream: list = {1, 2, 3}; assert `rst` between clock edges. Required: `out_ptr_vld = 0` and `count = 0` immediately, before the next edge.

Source files
------------

// File: rtl/ptr_pkg.sv
// Shared pointer types for the linked-list queue, the request generator and the bench.
package ptr_pkg;
    localparam int PTR_W = 4;
    localparam int N_PTR = 2 ** PTR_W;

    typedef logic [PTR_W-1:0] Pointer;
    typedef logic [PTR_W:0]   count_t;
endpackage

// File: rtl/ptr_chain_if.sv
// Push/pop port bundle of ptr_chain; slave is the queue, master is the producer/consumer side.
interface ptr_chain_if;
    import ptr_pkg::*;

    // Push side has no ready: a valid pointer is always taken.
    // Pop side: the head leaves on any cycle where out_ptr_vld && out_ptr_rdy.
    Pointer in_ptr;
    logic   in_ptr_vld;
    Pointer out_ptr;
    logic   out_ptr_vld;
    logic   out_ptr_rdy;
    count_t count;
    logic   empty;
    logic   dup_err;

    modport slave (
        input  in_ptr, in_ptr_vld, out_ptr_rdy,
        output out_ptr, out_ptr_vld, count, empty, dup_err
    );

    modport master (
        output in_ptr, in_ptr_vld, out_ptr_rdy,
        input  out_ptr, out_ptr_vld, count, empty, dup_err
    );
endinterface

// File: rtl/ptr_next_ram.sv
// Next-pointer array: one synchronous write port, one asynchronous read port, no reset.
module ptr_next_ram
    import ptr_pkg::*;
(
    input  logic   clk,
    input  logic   we,
    input  Pointer waddr,
    input  Pointer wdata,
    input  Pointer raddr,
    output Pointer rdata
);
    Pointer mem [N_PTR];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ptr_chain.sv
// Linked-list pointer queue: append at tail, drain from head in arrival order.
// Optional duplicate-push rejection with PTR_CHAIN_DUP_CHECK_EN.
module ptr_chain
    import ptr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ptr_chain_if.slave  bus
);
    localparam count_t CNT_ONE  = count_t'(1);
    localparam count_t CNT_ZERO = count_t'(0);

    Pointer head;
    Pointer tail;
    count_t count;
    Pointer next_head;
    logic   pop;
    logic   push;
    logic   single;

    assign pop    = (count != CNT_ZERO) && bus.out_ptr_rdy;
    assign single = (count == CNT_ONE);

`ifdef PTR_CHAIN_DUP_CHECK_EN
    logic [N_PTR-1:0] in_list;
    logic [N_PTR-1:0] in_list_d;
    logic             dup;
    logic             dup_err_q;

    // Re-pushing the pointer that is leaving this cycle is legal.
    assign dup  = bus.in_ptr_vld && in_list[bus.in_ptr] && !(pop && head == bus.in_ptr);
    assign push = bus.in_ptr_vld && !dup;

    always_comb begin
        in_list_d = in_list;
        if (pop)  in_list_d[head]       = 1'b0;
        if (push) in_list_d[bus.in_ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_list   <= '0;
            dup_err_q <= 1'b0;
        end else begin
            in_list   <= in_list_d;
            dup_err_q <= dup;
        end
    end

    assign bus.dup_err = dup_err_q;
`else
    assign push        = bus.in_ptr_vld;
    assign bus.dup_err = 1'b0;
`endif

    // A push onto a list that is (or is becoming) empty needs no link write.
    ptr_next_ram u_next (
        .clk   (clk),
        .we    (push && (count != CNT_ZERO) && !(pop && single)),
        .waddr (tail),
        .wdata (bus.in_ptr),
        .raddr (head),
        .rdata (next_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push && ((count == CNT_ZERO) || (pop && single))) head <= bus.in_ptr;
            else if (pop)                                          head <= next_head;

            if (push) tail <= bus.in_ptr;

            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

    assign bus.out_ptr     = head;
    assign bus.out_ptr_vld = (count != CNT_ZERO);
    assign bus.count       = count;
    assign bus.empty       = (count == CNT_ZERO);
endmodule

// File: tb/tb_ptr_chain.sv
// Directed bench for ptr_chain with hand-computed expectations.
module tb_ptr_chain;
    import ptr_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ptr_chain_if bus ();

    ptr_chain dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and land 1 ns after the edge.
    task automatic cycle(input logic vld, input int p, input logic rdy);
        bus.in_ptr_vld  = vld;
        bus.in_ptr      = Pointer'(p);
        bus.out_ptr_rdy = rdy;
        @(posedge clk);
        #1;
        bus.in_ptr_vld  = 1'b0;
        bus.out_ptr_rdy = 1'b0;
    endtask

    task automatic expect_head(input string tag, input int p, input int cnt);
        check({tag, "_vld"},   bus.out_ptr_vld, 1);
        check({tag, "_ptr"},   bus.out_ptr, p);
        check({tag, "_count"}, bus.count, cnt);
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_vld"},   bus.out_ptr_vld, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_empty"}, bus.empty, 1);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b0;
        bus.in_ptr      = '0;
        bus.in_ptr_vld  = 1'b0;
        bus.out_ptr_rdy = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_ptr", bus.out_ptr, 0);
        check("rst_dup_err", bus.dup_err, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_empty("idle");
            cycle(1'b0, 0, 1'b1);
        end

        // In-order drain
        cycle(1'b1, 3, 1'b0);
        expect_head("push3", 3, 1);
        cycle(1'b1, 7, 1'b0);
        cycle(1'b1, 1, 1'b0);
        expect_head("push1", 3, 3);
        cycle(1'b0, 0, 1'b1);
        expect_head("drain7", 7, 2);
        cycle(1'b0, 0, 1'b1);
        expect_head("drain1", 1, 1);
        cycle(1'b0, 0, 1'b1);
        expect_empty("drained");

        // Push plus pop on a single-node list
        cycle(1'b1, 5, 1'b0);
        expect_head("single5", 5, 1);
        cycle(1'b1, 9, 1'b1);
        expect_head("swap9", 9, 1);
        cycle(1'b0, 0, 1'b1);
        expect_empty("swap_drained");

        // Push plus pop with more than one node
        cycle(1'b1, 10, 1'b0);
        cycle(1'b1, 11, 1'b0);
        cycle(1'b1, 12, 1'b1);
        expect_head("pp_11", 11, 2);
        cycle(1'b0, 0, 1'b1);
        expect_head("pp_12", 12, 1);
        cycle(1'b0, 0, 1'b1);
        expect_empty("pp_drained");

        // Fill to full and drain in order
        for (int i = 0; i < N_PTR; i++) cycle(1'b1, i, 1'b0);
        check("full_count", bus.count, 16);
        check("full_empty", bus.empty, 0);
        check("full_dup_err", bus.dup_err, 0);
        for (int i = 0; i < N_PTR; i++) begin
            expect_head("fill_pop", i, N_PTR - i);
            cycle(1'b0, 0, 1'b1);
        end
        expect_empty("fill_drained");

`ifdef PTR_CHAIN_DUP_CHECK_EN
        // Duplicate rejection, then legal re-push of the leaving head
        cycle(1'b1, 2, 1'b0);
        cycle(1'b1, 4, 1'b0);
        cycle(1'b1, 4, 1'b0);
        check("dup_err_pulse", bus.dup_err, 1);
        expect_head("dup_kept", 2, 2);
        cycle(1'b0, 0, 1'b0);
        check("dup_err_clear", bus.dup_err, 0);
        check("dup_count", bus.count, 2);
        cycle(1'b1, 2, 1'b1);
        check("repush_dup_err", bus.dup_err, 0);
        expect_head("repush_4", 4, 2);
        cycle(1'b0, 0, 1'b1);
        expect_head("repush_2", 2, 1);
        cycle(1'b0, 0, 1'b1);
        expect_empty("dup_drained");
`endif

        // Asynchronous reset between edges
        cycle(1'b1, 1, 1'b0);
        cycle(1'b1, 2, 1'b0);
        cycle(1'b1, 3, 1'b0);
        expect_head("pre_arst", 1, 3);
        bus.in_ptr_vld = 1'b1;
        bus.in_ptr     = Pointer'(6);
        #2;
        rst = 1'b0;
        #1;
        expect_empty("arst_now");
        check("arst_out_ptr", bus.out_ptr, 0);
        @(posedge clk);
        #1;
        bus.in_ptr_vld = 1'b0;
        expect_empty("arst_held");
        rst = 1'b1;
        cycle(1'b0, 0, 1'b0);
        expect_empty("arst_released");
        cycle(1'b1, 8, 1'b0);
        expect_head("post_arst", 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
